// File: rtl/memory.sv
// -----------------------------------------------------------------------------
// memory
//
// Single-port 1024 x 16 synchronous RAM used as the general-purpose data and
// instruction store of the CPU datapath. One access happens on every rising
// clock edge, selected by a single shared read/write line:
//   rw_enable = 0 : write data_in to mem[address]; data_out keeps its value
//   rw_enable = 1 : data_out <= mem[address] (one-cycle read latency)
//
// Ports
//   clk        in  1   rising-edge clock
//   rst_n      in  1   synchronous, active-low reset
//   rw_enable  in  1   0 = write, 1 = read
//   address    in  10  word address 0x000..0x3FF
//   data_in    in  16  write data
//   data_out   out 16  registered read data
//
// Reset clears data_out and blocks any write presented in the same cycle.
// Array contents survive reset unless the build defines MEMORY_CLEAR_EN, in
// which case every reset edge also zeroes all 1024 words in that one edge.
// -----------------------------------------------------------------------------
module memory (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rw_enable,
    input  logic [9:0]  address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out
);

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_en;
    logic rd_en;

    // Reset outranks the access; there is no idle cycle, so exactly one of
    // the two strobes is high whenever reset is released.
    assign wr_en = rst_n && !rw_enable;
    assign rd_en = rst_n &&  rw_enable;

    // Storage array
`ifdef MEMORY_CLEAR_EN
    // Whole-array clear in a single edge; this keeps the array out of block
    // RAM but guarantees every unwritten word reads back as zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[address] <= data_in;
        end
    end
`else
    // Contents are retained across reset; only the write is suppressed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[address] <= data_in;
        end
    end
`endif

    // Read register: loads only on read cycles so a write cycle leaves the
    // previous read result visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_en) begin
            data_out <= mem[address];
        end
    end

endmodule

// File: tb/tb_memory.sv
module tb_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rw_enable = 1'b1;
    logic [9:0]  address = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain array of words plus a "has been written" flag.
    logic [15:0] ref_mem   [1024];
    bit          ref_known [1024];
    logic [15:0] ref_out;

    memory dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rw_enable (rw_enable),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: drive at the falling edge, let the rising edge
    // act, update the model and return 1 time unit after the edge.
    task automatic cycle(input logic rst_v, input logic rw,
                         input logic [9:0] a, input logic [15:0] d);
        @(negedge clk);
        rst_n     = rst_v;
        rw_enable = rw;
        address   = a;
        data_in   = d;
        @(posedge clk);
        #1;
        if (!rst_v) begin
            ref_out = 16'h0000;
`ifdef MEMORY_CLEAR_EN
            for (int i = 0; i < 1024; i++) begin
                ref_mem[i]   = 16'h0000;
                ref_known[i] = 1'b1;
            end
`endif
        end else if (rw) begin
            ref_out = ref_known[a] ? ref_mem[a] : 16'hxxxx;
        end else begin
            ref_mem[a]   = d;
            ref_known[a] = 1'b1;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b0, 10'h005, 16'hDEAD);
            n_checks++;
            if (data_out !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_out[%0d]: got %h expected 0000", k, data_out);
            end
        end
        cycle(1'b1, 1'b1, 10'h005, 16'h0000);
        n_checks++;
`ifdef MEMORY_CLEAR_EN
        if (data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_write_dropped: got %h expected 0000", data_out);
        end
`else
        if (data_out === 16'hDEAD) begin
            n_fail++;
            $display("FAIL reset_write_dropped: got %h expected not DEAD", data_out);
        end
`endif
    endtask

    task automatic test_basic();
        cycle(1'b1, 1'b0, 10'h000, 16'h1234);
        cycle(1'b1, 1'b0, 10'h1FF, 16'h4321);
        cycle(1'b1, 1'b1, 10'h000, 16'h0000);
        n_checks++;
        if (data_out !== 16'h1234) begin
            n_fail++;
            $display("FAIL basic_rd_000: got %h expected 1234", data_out);
        end
        cycle(1'b1, 1'b1, 10'h1FF, 16'h0000);
        n_checks++;
        if (data_out !== 16'h4321) begin
            n_fail++;
            $display("FAIL basic_rd_1ff: got %h expected 4321", data_out);
        end
    endtask

    task automatic test_boundary();
        cycle(1'b1, 1'b0, 10'h3FF, 16'hAAAA);
        cycle(1'b1, 1'b0, 10'h000, 16'h5555);
        cycle(1'b1, 1'b1, 10'h3FF, 16'h0000);
        n_checks++;
        if (data_out !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL boundary_rd_3ff: got %h expected AAAA", data_out);
        end
        cycle(1'b1, 1'b1, 10'h000, 16'h0000);
        n_checks++;
        if (data_out !== 16'h5555) begin
            n_fail++;
            $display("FAIL boundary_rd_000: got %h expected 5555", data_out);
        end
    endtask

    task automatic test_hold_on_write();
        cycle(1'b1, 1'b0, 10'h000, 16'h1234);
        cycle(1'b1, 1'b1, 10'h000, 16'h0000);
        n_checks++;
        if (data_out !== 16'h1234) begin
            n_fail++;
            $display("FAIL hold_pre_read: got %h expected 1234", data_out);
        end
        cycle(1'b1, 1'b0, 10'h010, 16'hBEEF);
        n_checks++;
        if (data_out !== 16'h1234) begin
            n_fail++;
            $display("FAIL hold_during_write: got %h expected 1234", data_out);
        end
        cycle(1'b1, 1'b1, 10'h010, 16'h0000);
        n_checks++;
        if (data_out !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL hold_rd_010: got %h expected BEEF", data_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_after;
        cycle(1'b1, 1'b1, 10'h000, 16'h0000);
        cycle(1'b0, 1'b1, 10'h1FF, 16'h0000);
        n_checks++;
        if (data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset_rd: got %h expected 0000", data_out);
        end
`ifdef MEMORY_CLEAR_EN
        exp_after = 16'h0000;
`else
        exp_after = 16'h4321;
`endif
        cycle(1'b1, 1'b1, 10'h1FF, 16'h0000);
        n_checks++;
        if (data_out !== exp_after) begin
            n_fail++;
            $display("FAIL mid_reset_after: got %h expected %h", data_out, exp_after);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  a;
        logic [15:0] d;
        for (int k = 0; k < 16; k++) begin
            a = 10'($urandom_range(0, 1023));
            d = 16'($urandom);
            cycle(1'b1, 1'b0, a, d);
            cycle(1'b1, 1'b1, a, 16'h0000);
            n_checks++;
            if (data_out !== ref_mem[a]) begin
                n_fail++;
                $display("FAIL b2b[%0d] addr %h: got %h expected %h", k, a, data_out, ref_mem[a]);
            end
        end
    endtask

    task automatic test_random();
        logic        r;
        logic        rw;
        logic [9:0]  a;
        logic [15:0] d;
        for (int k = 0; k < 400; k++) begin
            r  = ($urandom_range(0, 39) != 0);
            rw = 1'($urandom_range(0, 1));
            a  = 10'($urandom_range(0, 31)) + 10'h200;
            d  = 16'($urandom);
            cycle(r, rw, a, d);
            if (!$isunknown(ref_out)) begin
                n_checks++;
                if (data_out !== ref_out) begin
                    n_fail++;
                    $display("FAIL random[%0d] rst_n=%0b rw=%0b addr %h: got %h expected %h",
                             k, r, rw, a, data_out, ref_out);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ref_known[i] = 1'b0;
            ref_mem[i]   = 16'hxxxx;
        end
        ref_out = 16'h0000;
        test_reset();
        test_basic();
        test_boundary();
        test_hold_on_write();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory.md
# memory

Single-port 1024 x 16 synchronous RAM with one shared read/write control line. Serves as the general-purpose data/instruction store of the CPU datapath. One access per clock: a write stores `data_in` at `address`; a read returns the stored word on `data_out` one clock edge later.

## Interface
- Parameters: none. Depth fixed at 1024 words, width fixed at 16 bits.
- `clk` in 1: rising-edge clock; all state changes on this edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `rw_enable` in 1: access select. 0 = write, 1 = read.
- `address` in 10: word address, 0x000–0x3FF.
- `data_in` in 16: write data, sampled at the write edge.
- `data_out` out 16: registered read data.

## Operation
- Storage: array of 1024 x 16-bit words.
- Every rising edge with `rst_n`=1 performs exactly one access:
  - Write (`rw_enable`=0): `mem[address] <= data_in`. `data_out` holds its previous value.
  - Read (`rw_enable`=1): `data_out <= mem[address]`. Memory is unchanged.
- There is no idle state. Every cycle out of reset is either a read or a write. A bench that wants no change must issue reads.
- Address is the full 10 bits: no wrap logic, no out-of-range case.
- Write is full-word only: no byte enables, no partial writes.
- Reset (`rst_n`=0 at an edge):
  - `data_out` <= 16'h0000.
  - Writes are inhibited regardless of `rw_enable`.
  - Array contents are kept unless `MEMORY_CLEAR_EN` is defined (see Configuration).
- Reset has priority over any access in the same cycle.
- Reading a never-written word returns an undefined value (X in simulation), unless the clear feature is enabled.

## Timing
- Write latency: the word is stored at the edge where `rw_enable`=0 is sampled. A read of the same address issued on the next cycle returns the new value.
- Read latency: 1 cycle. `data_out` is valid after the edge that sampled `rw_enable`=1 and `address`, and stays stable until the next read edge or reset edge.
- No read-during-write case exists, since there is a single port and a single access per cycle.
- Reset asserted mid-operation:
  - An in-flight read result is replaced by 0.
  - A write presented in a reset cycle is dropped.
  - Behaviour is normal from the first edge with `rst_n`=1.
- Inputs must be stable around the rising edge. No combinational path from inputs to `data_out`.

## Configuration
- `MEMORY_CLEAR_EN` defined:
  - Every reset edge also writes 16'h0000 to all 1024 words, all in the same edge.
  - After reset, reading any unwritten address returns 16'h0000.
- `MEMORY_CLEAR_EN` undefined:
  - Reset affects only `data_out`.
  - Array contents survive reset. Unwritten words are undefined.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `rw_enable`=0, `address`=0x005, `data_in`=0xDEAD -> `data_out`=0x0000. Then a read of 0x005 must not return 0xDEAD.
- Basic write/read:
  - write 0x1234 @0x000;
  - write 0x4321 @0x1FF;
  - read 0x000 -> `data_out`=0x1234 one edge later;
  - read 0x1FF -> 0x4321.
- Boundary addresses: write 0xAAAA @0x3FF and 0x5555 @0x000, then read both -> 0xAAAA, 0x5555. Neither write disturbs the other.
- Hold on write: read 0x000 (0x1234), then write 0xBEEF @0x010 -> `data_out` stays 0x1234 during the write cycle. A subsequent read of 0x010 -> 0xBEEF.
- Reset mid-operation:
  - read 0x1FF while `rst_n`=0 -> `data_out`=0x0000;
  - after release, read 0x1FF -> 0x4321 without `MEMORY_CLEAR_EN`, 0x0000 with it.
- Back-to-back: write then read the same address on consecutive cycles, across 16 random addresses -> every read returns the last value written.
